// File: rtl/microwave_cook_sequencer.sv
// microwave_cook_sequencer
//
// Purpose:
//   Top-level control sequencer for the microwave oven datapath. It collects
//   keypad digits into an M:SS entry buffer, validates the entry when start is
//   pressed, loads and enables the external countdown timer, gates the
//   magnetron with a power-level duty cycle stepped by the 1 Hz tick, and
//   sounds the end-of-cook beep.
//
// Parameters:
//   BEEP_SECS   - number of 1 Hz ticks the beep stays high in DONE (1..15)
//   MAX_POWER   - highest power level; also the duty-cycle period in ticks
//
// Ports:
//   clock        in   system clock, rising edge
//   resetn       in   synchronous active-low reset
//   keypad       in   [9:0] one-hot digit key, sampled on key_strobe
//   key_strobe   in   one-cycle pulse, keypad holds a new key
//   power_key    in   one-cycle pulse, step the power level down
//   start_pulse  in   one-cycle start request
//   stop_pulse   in   one-cycle stop/clear request
//   door_closed  in   level, 1 = door closed
//   tick_1hz     in   one-cycle pulse once per second
//   timer_zero   in   level from the timer, count is 0:00
//   digit_mins   out  [3:0] entry minutes digit (timer D input)
//   digit_tens   out  [3:0] entry tens-of-seconds digit
//   digit_ones   out  [3:0] entry ones-of-seconds digit
//   timer_load   out  one-cycle load strobe to the timer
//   timer_en     out  countdown enable to the timer
//   mag_on       out  magnetron drive (combinational on door_closed)
//   beep         out  buzzer drive
//   err          out  one-cycle pulse, start rejected
//   power_level  out  [3:0] current power level 1..MAX_POWER
//   state        out  [2:0] FSM state code for debug

module microwave_cook_sequencer #(
  parameter int BEEP_SECS = 3,
  parameter int MAX_POWER = 10
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] keypad,
  input  logic       key_strobe,
  input  logic       power_key,
  input  logic       start_pulse,
  input  logic       stop_pulse,
  input  logic       door_closed,
  input  logic       tick_1hz,
  input  logic       timer_zero,
  output logic [3:0] digit_mins,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       timer_load,
  output logic       timer_en,
  output logic       mag_on,
  output logic       beep,
  output logic       err,
  output logic [3:0] power_level,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     cur_state;
  logic [3:0] duty_cnt;
  logic [3:0] beep_cnt;
  logic [3:0] key_index;
  logic       key_valid;
  logic       start_ok;
  logic [3:0] next_power;

  // A strobe only counts when exactly one key is down; the index of that key
  // becomes the digit shifted into the buffer.
  assign key_valid = $onehot(keypad);

  always_comb begin
    key_index = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_index = 4'(i);
    end
  end

  // An entry is cookable only with the door shut, a sane seconds field and a
  // non-zero time.
  assign start_ok = door_closed && (digit_tens <= 4'd5) &&
                    ({digit_mins, digit_tens, digit_ones} != 12'd0);

  // Power steps downward and wraps from 1 back to full power.
  assign next_power = (power_level == 4'd1) ? 4'(MAX_POWER) : power_level - 4'd1;

  // Main sequencer: state, entry buffer, power level, duty and beep counters,
  // and the registered err pulse all live in this one block.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cur_state   <= IDLE;
      digit_mins  <= 4'd0;
      digit_tens  <= 4'd0;
      digit_ones  <= 4'd0;
      power_level <= 4'(MAX_POWER);
      duty_cnt    <= 4'd0;
      beep_cnt    <= 4'd0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (cur_state)
        IDLE: begin
          if (key_strobe && key_valid) begin
            digit_mins <= digit_tens;
            digit_tens <= digit_ones;
            digit_ones <= key_index;
            cur_state  <= ENTRY;
          end
          if (power_key) power_level <= next_power;
        end

        ENTRY: begin
          if (power_key) power_level <= next_power;
          // Stop beats start, and both beat a key arriving in the same cycle.
          if (stop_pulse) begin
            digit_mins <= 4'd0;
            digit_tens <= 4'd0;
            digit_ones <= 4'd0;
            cur_state  <= IDLE;
          end else if (start_pulse) begin
            if (start_ok) cur_state <= LOAD;
            else          err       <= 1'b1;
          end else if (key_strobe && key_valid) begin
            digit_mins <= digit_tens;
            digit_tens <= digit_ones;
            digit_ones <= key_index;
          end
        end

        LOAD: begin
          duty_cnt  <= 4'd0;
          cur_state <= COOK;
        end

        COOK: begin
          if (tick_1hz) begin
            duty_cnt <= (duty_cnt == 4'(MAX_POWER - 1)) ? 4'd0 : duty_cnt + 4'd1;
          end
          // Timer expiry outranks a door opening or a stop in the same cycle.
          if (timer_zero) begin
            beep_cnt  <= 4'd0;
            cur_state <= DONE;
          end else if (!door_closed || stop_pulse) begin
            cur_state <= PAUSE;
          end
        end

        PAUSE: begin
          if (stop_pulse) begin
            digit_mins <= 4'd0;
            digit_tens <= 4'd0;
            digit_ones <= 4'd0;
            cur_state  <= IDLE;
          end else if (start_pulse) begin
            if (door_closed) cur_state <= COOK;
            else             err       <= 1'b1;
          end
        end

        DONE: begin
          if (stop_pulse) begin
            digit_mins <= 4'd0;
            digit_tens <= 4'd0;
            digit_ones <= 4'd0;
            cur_state  <= IDLE;
          end else if (tick_1hz) begin
            // Leave on the tick that brings the count up to BEEP_SECS.
            if (beep_cnt == 4'(BEEP_SECS - 1)) begin
              digit_mins <= 4'd0;
              digit_tens <= 4'd0;
              digit_ones <= 4'd0;
              cur_state  <= IDLE;
            end else begin
              beep_cnt <= beep_cnt + 4'd1;
            end
          end
        end

        default: cur_state <= IDLE;
      endcase
    end
  end

  // State decodes; only mag_on looks at a live input so an opening door cuts
  // the magnetron without waiting for a clock edge.
  assign state      = cur_state;
  assign timer_load = (cur_state == LOAD);
  assign timer_en   = (cur_state == COOK);
  assign beep       = (cur_state == DONE);
  assign mag_on     = (cur_state == COOK) && door_closed && (duty_cnt < power_level);

endmodule

// File: doc/microwave_cook_sequencer.md
Name: microwave_cook_sequencer

Overview:
- Top-level sequencer for the microwave oven datapath.
- Collects keypad digits into an M:SS entry buffer and validates it, then drives the minutes/seconds countdown timer via load/enable.
- Gates the magnetron with a power-level duty cycle on the 1 Hz tick, and runs an end-of-cook beep.
- Sits between the keypad/button synchronisers and the existing timer, magnetron and 7-segment decoder blocks.

Parameters:
- BEEP_SECS, 3, number of 1 Hz ticks the beep stays high in DONE (1..15).
- MAX_POWER, 10, power levels 1..MAX_POWER; also the duty-cycle period in ticks.

Ports:
- clock, input, 1, system clock; all logic is on the rising edge.
- resetn, input, 1, synchronous active-low reset.
- keypad, input, 10, one-hot digit key (bit k = digit k); sampled only when key_strobe=1.
- key_strobe, input, 1, one-cycle pulse: keypad holds a new key.
- power_key, input, 1, one-cycle pulse: step the power level.
- start_pulse, input, 1, one-cycle start request.
- stop_pulse, input, 1, one-cycle stop/clear request.
- door_closed, input, 1, level: 1 = door closed.
- tick_1hz, input, 1, one-cycle pulse once per second.
- timer_zero, input, 1, level from the timer: count is 0:00.
- digit_mins, output, 4, entry buffer minutes digit; feeds the timer D inputs.
- digit_tens, output, 4, entry buffer tens-of-seconds digit.
- digit_ones, output, 4, entry buffer ones-of-seconds digit.
- timer_load, output, 1, one-cycle load strobe to the timer.
- timer_en, output, 1, countdown enable to the timer.
- mag_on, output, 1, magnetron drive.
- beep, output, 1, buzzer drive.
- err, output, 1, one-cycle pulse: start rejected.
- power_level, output, 4, current power level 1..MAX_POWER.
- state, output, 3, FSM state code for debug.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE, all digits=0, power_level=MAX_POWER, duty_cnt=0, beep_cnt=0.
  - timer_load, timer_en, mag_on, beep and err all 0.
- State codes: IDLE=0, ENTRY=1, LOAD=2, COOK=3, PAUSE=4, DONE=5.
- Digit entry (IDLE or ENTRY only):
  - On key_strobe with keypad exactly one-hot: mins<=tens, tens<=ones, ones<=index; state->ENTRY.
  - A fourth digit shifts the oldest out.
  - Non-one-hot keypad (zero bits or multiple bits): strobe ignored, no state change.
  - key_strobe in any other state is ignored.
- Power key (IDLE or ENTRY only): power_level decrements by 1; from 1 it wraps to MAX_POWER. Ignored in other states.
- ENTRY + start_pulse:
  - Rejected when door_closed=0, tens>5, or all digits are 0: err=1 for one cycle, state stays ENTRY.
  - Otherwise -> LOAD.
- LOAD (exactly 1 cycle): timer_load=1, duty_cnt<=0; next state COOK.
- COOK:
  - timer_en=1.
  - On tick_1hz: duty_cnt increments, wrapping MAX_POWER-1 -> 0.
  - mag_on = door_closed AND (duty_cnt < power_level), combinational. At power MAX_POWER the magnetron is always on.
- COOK exits, in priority order:
  1. timer_zero=1 -> DONE.
  2. door_closed=0 -> PAUSE.
  3. stop_pulse -> PAUSE.
- PAUSE:
  - timer_en=0, mag_on=0; digits and duty_cnt are retained.
  - stop_pulse -> IDLE and clear digits (stop wins over a simultaneous start).
  - start_pulse with door_closed=1 -> COOK, no reload.
  - start_pulse with door open: err pulse, stay in PAUSE.
- DONE:
  - beep=1, timer_en=0, mag_on=0; beep_cnt<=0 on entry.
  - Each tick_1hz increments beep_cnt; when it reaches BEEP_SECS -> IDLE with digits cleared.
  - stop_pulse -> IDLE immediately.
- ENTRY + stop_pulse: clear digits, -> IDLE. Stop beats start in the same cycle.
- IDLE + stop_pulse or start_pulse: no effect; start in IDLE does not raise err.
- Output timing: all outputs except mag_on are registered or pure state decodes, so they change one cycle after the causing input. A door opening therefore drops mag_on in the same cycle.
- resetn=0 mid-cook forces the full reset values on the next edge; timer_en and mag_on deassert.
- A state code of 6 or 7 returns to IDLE on the next cycle.

Test Plan:
1. Reset, then keys 1,3,0 -> digits 1,3,0, state=ENTRY; start with door closed -> timer_load high exactly 1 cycle, then state=COOK, timer_en=1, mag_on=1.
2. Enter 0,7,5 and start -> err pulse, state stays ENTRY; enter 0,0,0 and start -> err; door open with a valid entry -> err.
3. Power key ×5 from reset -> power_level=5; in COOK over 20 ticks -> mag_on high for duty_cnt 0..4, i.e. 10 of 20 ticks. Power key ×10 from reset -> wraps back to 10.
4. COOK, then door_closed=0 -> mag_on=0 in the same cycle, PAUSE next cycle; close door and start -> COOK with duty_cnt retained and no timer_load.
5. COOK, timer_zero and stop_pulse in the same cycle -> DONE; beep high for exactly 3 ticks, then IDLE with digits=0.
6. Keys 1,2,3,4 -> digits 2,3,4; key_strobe with keypad=10'b0000000011 -> ignored; resetn=0 during COOK -> all reset values on the next edge.
